pipeline_hazard_controller: RTL and testbench

- Sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the enable and flush controls of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Generates EX-stage operand forwarding selects.
- Keeps shadow copies of per-stage writeback info, so it resolves load-use, taken-branch and memory-wait hazards without reading the pipeline registers.

---
 rtl/pipeline_hazard_controller.sv | 139 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing controller for a 5-stage pipeline: stall/flush control,
// EX-stage forwarding selects and a saturating stall counter.
module pipeline_hazard_controller #(
   parameter int NREG_BITS = 3,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 id_valid,
   input  logic [NREG_BITS-1:0] id_rn,
   input  logic [NREG_BITS-1:0] id_rm,
   input  logic                 id_uses_rn,
   input  logic                 id_uses_rm,
   input  logic                 id_write,
   input  logic [NREG_BITS-1:0] id_write_num,
   input  logic                 id_is_load,
   input  logic                 id_is_mem,
   input  logic                 ex_branch_taken,
   input  logic                 mem_ready,
   output logic                 pc_en,
   output logic                 if_id_en,
   output logic                 if_id_flush,
   output logic                 id_ex_en,
   output logic                 id_ex_flush,
   output logic                 ex_mem_en,
   output logic                 mem_wb_en,
   output logic                 mem_wb_flush,
   output logic [1:0]           fwd_a,
   output logic [1:0]           fwd_b,
   output logic [CNT_W-1:0]     stall_count
);

   logic                 ex_valid, ex_write, ex_load, ex_mem, ex_uses_rn, ex_uses_rm;
   logic [NREG_BITS-1:0] ex_num, ex_rn, ex_rm;
   logic                 mem_valid, mem_write, mem_load, mem_mem;
   logic [NREG_BITS-1:0] mem_num;
   logic                 wb_valid, wb_write;
   logic [NREG_BITS-1:0] wb_num;

   logic mem_wait, load_use, branch;

   assign mem_wait = mem_valid & mem_mem & ~mem_ready;
   assign load_use = ex_valid & ex_load & ex_write & id_valid &
                     ((id_uses_rn & (id_rn == ex_num)) | (id_uses_rm & (id_rm == ex_num)));
   assign branch   = ex_branch_taken & ex_valid;

   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b1;
      id_ex_flush  = 1'b0;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      mem_wb_flush = 1'b0;
      if (mem_wait) begin
         // MEM holds; WB drains with a bubble every waiting cycle
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (branch) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   function automatic logic [1:0] fwd_sel(input logic uses, input logic [NREG_BITS-1:0] r);
      fwd_sel = 2'b00;
      if (ex_valid && uses) begin
         if (mem_valid && mem_write && !mem_load && (mem_num == r))
            fwd_sel = 2'b10;
         else if (wb_valid && wb_write && (wb_num == r))
            fwd_sel = 2'b01;
      end
   endfunction

   assign fwd_a = fwd_sel(ex_uses_rn, ex_rn);
   assign fwd_b = fwd_sel(ex_uses_rm, ex_rm);

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid   <= 1'b0;
         ex_write   <= 1'b0;
         ex_load    <= 1'b0;
         ex_mem     <= 1'b0;
         ex_uses_rn <= 1'b0;
         ex_uses_rm <= 1'b0;
         ex_num     <= '0;
         ex_rn      <= '0;
         ex_rm      <= '0;
         mem_valid  <= 1'b0;
         mem_write  <= 1'b0;
         mem_load   <= 1'b0;
         mem_mem    <= 1'b0;
         mem_num    <= '0;
         wb_valid   <= 1'b0;
         wb_write   <= 1'b0;
         wb_num     <= '0;
      end else begin
         if (mem_wb_en) begin
            wb_valid <= mem_wb_flush ? 1'b0 : mem_valid;
            wb_write <= mem_write;
            wb_num   <= mem_num;
         end
         if (ex_mem_en) begin
            mem_valid <= ex_valid;
            mem_write <= ex_write;
            mem_load  <= ex_load;
            mem_mem   <= ex_mem;
            mem_num   <= ex_num;
         end
         if (id_ex_en) begin
            ex_valid   <= id_ex_flush ? 1'b0 : id_valid;
            ex_write   <= id_write;
            ex_load    <= id_is_load;
            ex_mem     <= id_is_mem;
            ex_uses_rn <= id_uses_rn;
            ex_uses_rm <= id_uses_rm;
            ex_num     <= id_write_num;
            ex_rn      <= id_rn;
            ex_rm      <= id_rm;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         stall_count <= '0;
      else if (!pc_en && (stall_count != {CNT_W{1'b1}}))
         stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed test-plan scenarios followed by
// randomized instruction streams, all checked against a stage-list reference model.
module tb_pipeline_hazard_controller;

   localparam int NB = 3;
   localparam int CW = 4;
   localparam int SAT = (1 << CW) - 1;

   logic clk = 1'b0;
   logic reset;
   logic id_valid, id_uses_rn, id_uses_rm, id_write, id_is_load, id_is_mem;
   logic [NB-1:0] id_rn, id_rm, id_write_num;
   logic ex_branch_taken, mem_ready;
   logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush;
   logic [1:0] fwd_a, fwd_b;
   logic [CW-1:0] stall_count;

   pipeline_hazard_controller #(.NREG_BITS(NB), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
      .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
      .id_write(id_write), .id_write_num(id_write_num),
      .id_is_load(id_is_load), .id_is_mem(id_is_mem),
      .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
      .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
      .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: each stage holds an instruction record or is empty.
   typedef struct {
      bit valid, write, load, mem, uses_rn, uses_rm;
      int num, rn, rm;
   } ins_t;

   ins_t m_ex, m_mem, m_wb;
   int   m_stalls;
   bit   e_pc, e_ifid, e_ifid_fl, e_idex, e_idex_fl, e_exmem, e_memwb, e_memwb_fl;
   int   e_fa, e_fb;

   function automatic ins_t empty_ins();
      ins_t r;
      r.valid = 0; r.write = 0; r.load = 0; r.mem = 0; r.uses_rn = 0; r.uses_rm = 0;
      r.num = 0; r.rn = 0; r.rm = 0;
      return r;
   endfunction

   function automatic ins_t id_ins();
      ins_t r;
      r.valid = id_valid; r.write = id_write; r.load = id_is_load; r.mem = id_is_mem;
      r.uses_rn = id_uses_rn; r.uses_rm = id_uses_rm;
      r.num = int'(id_write_num); r.rn = int'(id_rn); r.rm = int'(id_rm);
      return r;
   endfunction

   // Which stage supplies register r to the EX instruction: 2 = MEM ALU result, 1 = WB, 0 = file.
   function automatic int source_of(bit uses, int r);
      if (!m_ex.valid || !uses) return 0;
      if (m_mem.valid && m_mem.write && !m_mem.load && m_mem.num == r) return 2;
      if (m_wb.valid && m_wb.write && m_wb.num == r) return 1;
      return 0;
   endfunction

   task automatic model_outputs();
      bit waiting, consumer_of_load, squash;
      waiting = m_mem.valid && m_mem.mem && !mem_ready;
      squash  = ex_branch_taken && m_ex.valid;
      consumer_of_load = m_ex.valid && m_ex.load && m_ex.write && id_valid &&
                         ((id_uses_rn && int'(id_rn) == m_ex.num) ||
                          (id_uses_rm && int'(id_rm) == m_ex.num));
      {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
      {e_ifid_fl, e_idex_fl, e_memwb_fl} = 3'b000;
      if (waiting) begin
         {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
         e_memwb_fl = 1;
      end else if (squash) begin
         e_ifid_fl = 1; e_idex_fl = 1;
      end else if (consumer_of_load) begin
         e_pc = 0; e_ifid = 0; e_idex_fl = 1;
      end
      e_fa = source_of(m_ex.uses_rn, m_ex.rn);
      e_fb = source_of(m_ex.uses_rm, m_ex.rm);
   endtask

   bit check_en = 0;

   task automatic check_outputs();
      #1;
      model_outputs();
      if (check_en) begin
         check("pc_en", pc_en, e_pc);
         check("if_id_en", if_id_en, e_ifid);
         check("if_id_flush", if_id_flush, e_ifid_fl);
         check("id_ex_en", id_ex_en, e_idex);
         check("id_ex_flush", id_ex_flush, e_idex_fl);
         check("ex_mem_en", ex_mem_en, e_exmem);
         check("mem_wb_en", mem_wb_en, e_memwb);
         check("mem_wb_flush", mem_wb_flush, e_memwb_fl);
         check("fwd_a", fwd_a, e_fa);
         check("fwd_b", fwd_b, e_fb);
         check("stall_count", stall_count, m_stalls);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      if (reset) begin
         m_ex = empty_ins(); m_mem = empty_ins(); m_wb = empty_ins();
         m_stalls = 0;
         check_en = 1;
      end else begin
         if (!e_pc && m_stalls < SAT) m_stalls++;
         if (e_memwb) m_wb = e_memwb_fl ? empty_ins() : m_mem;
         if (e_exmem) m_mem = m_ex;
         if (e_idex)  m_ex = e_idex_fl ? empty_ins() : id_ins();
      end
      @(negedge clk);
   endtask

   task automatic drive_id(input bit v, input int rn, input bit urn, input int rm, input bit urm,
                           input bit wr, input int wnum, input bit ld, input bit mm);
      id_valid = v; id_rn = NB'(rn); id_uses_rn = urn; id_rm = NB'(rm); id_uses_rm = urm;
      id_write = wr; id_write_num = NB'(wnum); id_is_load = ld; id_is_mem = mm;
   endtask

   task automatic nop();
      drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1; check_outputs(); advance(); reset = 0;
   endtask

   initial begin
      reset = 1; ex_branch_taken = 0; mem_ready = 1;
      nop();
      @(negedge clk);
      do_reset();

      // ADD R1 <- R2, R3 with nothing in flight
      drive_id(1, 2, 1, 3, 1, 1, 1, 0, 0);
      check_outputs();
      check("idle_pc_en", pc_en, 1);
      check("idle_fwd", {fwd_a, fwd_b}, 0);
      check("idle_stall_count", stall_count, 0);
      advance();

      // ADD R2 then two readers of R2: MEM forward, then WB forward
      drive_id(1, 0, 1, 1, 1, 1, 2, 0, 0);
      check_outputs(); advance();
      drive_id(1, 2, 1, 0, 0, 1, 5, 0, 0);
      check_outputs(); advance();
      drive_id(1, 2, 1, 0, 0, 1, 6, 0, 0);
      check_outputs();
      check("fwd_from_mem", fwd_a, 2'b10);
      advance();
      nop();
      check_outputs();
      check("fwd_from_wb", fwd_a, 2'b01);
      advance();

      // LDR R4 followed by a reader of R4: one bubble
      drive_id(1, 1, 1, 0, 0, 1, 4, 1, 1);
      check_outputs(); advance();
      drive_id(1, 4, 1, 0, 0, 1, 7, 0, 0);
      check_outputs();
      check("lu_pc_en", pc_en, 0);
      check("lu_id_ex_flush", id_ex_flush, 1);
      advance();
      check_outputs();
      check("lu_released", pc_en, 1);
      advance();
      nop();
      check_outputs();
      check("lu_fwd_wb", fwd_a, 2'b01);
      check("lu_stall_count", stall_count, 1);
      advance();

      // Taken branch squashes a simultaneous load-use
      drive_id(1, 0, 0, 0, 0, 1, 3, 1, 1);
      check_outputs(); advance();
      drive_id(1, 3, 1, 0, 0, 1, 2, 0, 0);
      ex_branch_taken = 1;
      check_outputs();
      check("br_flushes", {if_id_flush, id_ex_flush, pc_en}, 3'b111);
      advance();
      ex_branch_taken = 0;
      nop();
      check_outputs();
      check("br_stall_count", stall_count, 1);
      advance();

      // Three-cycle memory wait on a load in MEM
      do_reset();
      drive_id(1, 0, 0, 0, 0, 1, 1, 1, 1);
      check_outputs(); advance();
      nop();
      check_outputs(); advance();
      mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         check_outputs();
         check("mw_hold", {pc_en, mem_wb_flush}, 2'b01);
         advance();
      end
      mem_ready = 1;
      check_outputs();
      check("mw_resume", pc_en, 1);
      check("mw_stall_count", stall_count, 3);
      advance();

      // Reset in the middle of a memory wait
      drive_id(1, 0, 0, 0, 0, 1, 2, 1, 1);
      check_outputs(); advance();
      nop();
      check_outputs(); advance();
      mem_ready = 0;
      check_outputs(); advance();
      reset = 1;
      check_outputs(); advance();
      reset = 0;
      check_outputs();
      check("rst_mw_enables", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b11111);
      check("rst_mw_flushes", {if_id_flush, id_ex_flush, mem_wb_flush}, 3'b000);
      check("rst_mw_stall_count", stall_count, 0);
      advance();

      // Randomized instruction streams; small register space keeps hazards frequent
      for (int c = 0; c < 600; c++) begin
         id_valid        = ($urandom_range(0, 3) != 0);
         id_rn           = NB'($urandom_range(0, 7));
         id_rm           = NB'($urandom_range(0, 7));
         id_uses_rn      = $urandom_range(0, 1);
         id_uses_rm      = $urandom_range(0, 1);
         id_write        = ($urandom_range(0, 3) != 0);
         id_write_num    = NB'($urandom_range(0, 7));
         id_is_mem       = ($urandom_range(0, 2) == 0);
         id_is_load      = id_is_mem & $urandom_range(0, 1);
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         mem_ready       = ($urandom_range(0, 3) != 0);
         reset           = ($urandom_range(0, 99) == 0);
         check_outputs();
         advance();
      end
      reset = 0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
